// File: rtl/sram_access_ctrl.sv
// Request-level SRAM access controller: one read/write at a time, sequenced as precharge, then wordline-active, then a one-cycle response.
// Optional read forwarding from the last completed write is enabled with `define SRAM_ACCESS_CTRL_RD_FWD_EN.
module sram_access_ctrl #(
    parameter int WORD_SIZE  = 4,
    parameter int NUM_WORDS  = 16,
    parameter int NUM_ROWS   = 16,
    parameter int PRE_CYCLES = 1,
    parameter int ACC_CYCLES = 2,
    localparam int COL_W  = $clog2(NUM_WORDS),
    localparam int ROW_W  = $clog2(NUM_ROWS),
    localparam int ADDR_W = ROW_W + COL_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic                 precharge_en,
    output logic [NUM_ROWS-1:0]  wordline,
    output logic [NUM_WORDS-1:0] col_select,
    output logic                 write_en,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 sense_en,
    input  logic [WORD_SIZE-1:0] sense_data
);
    localparam int CNT_MAX = (PRE_CYCLES > ACC_CYCLES) ? PRE_CYCLES : ACC_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]     PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     ACC_LOAD = CNT_W'(ACC_CYCLES - 1);
    localparam logic [NUM_ROWS-1:0]  ROW_LSB  = NUM_ROWS'(1);
    localparam logic [NUM_WORDS-1:0] COL_LSB  = NUM_WORDS'(1);

    typedef enum logic [1:0] {IDLE, PRECHARGE, ACTIVE, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [ADDR_W-1:0]    lat_addr;
    logic                 lat_we;
    logic [WORD_SIZE-1:0] lat_wdata;
    logic                 fwd_hit;

`ifdef SRAM_ACCESS_CTRL_RD_FWD_EN
    logic                 lw_valid;
    logic [ADDR_W-1:0]    lw_addr;
    logic [WORD_SIZE-1:0] lw_data;

    assign fwd_hit = lw_valid && !req_we && (lw_addr == req_addr);
`else
    assign fwd_hit = 1'b0;
`endif

    // All array pins are registered and set on the edge that enters the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_addr     <= '0;
            lat_we       <= 1'b0;
            lat_wdata    <= '0;
            rsp_rdata    <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            precharge_en <= 1'b0;
            wordline     <= '0;
            col_select   <= '0;
            write_en     <= 1'b0;
            sense_en     <= 1'b0;
            data_out     <= '0;
`ifdef SRAM_ACCESS_CTRL_RD_FWD_EN
            lw_valid     <= 1'b0;
            lw_addr      <= '0;
            lw_data      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr  <= req_addr;
                        lat_we    <= req_we;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
`ifdef SRAM_ACCESS_CTRL_RD_FWD_EN
                        if (fwd_hit) begin
                            rsp_rdata <= lw_data;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt          <= PRE_LOAD;
                            precharge_en <= 1'b1;
                            state        <= PRECHARGE;
                        end
`else
                        cnt          <= PRE_LOAD;
                        precharge_en <= 1'b1;
                        state        <= PRECHARGE;
`endif
                    end
                end
                PRECHARGE: begin
                    if (cnt == '0) begin
                        cnt          <= ACC_LOAD;
                        precharge_en <= 1'b0;
                        wordline     <= ROW_LSB << lat_addr[ADDR_W-1:COL_W];
                        col_select   <= COL_LSB << lat_addr[COL_W-1:0];
                        write_en     <= lat_we;
                        sense_en     <= !lat_we;
                        data_out     <= lat_we ? lat_wdata : '0;
                        state        <= ACTIVE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cnt == '0) begin
                        if (!lat_we) rsp_rdata <= sense_data;
                        wordline   <= '0;
                        col_select <= '0;
                        write_en   <= 1'b0;
                        sense_en   <= 1'b0;
                        data_out   <= '0;
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
`ifdef SRAM_ACCESS_CTRL_RD_FWD_EN
                    if (lat_we) begin
                        lw_valid <= 1'b1;
                        lw_addr  <= lat_addr;
                        lw_data  <= lat_wdata;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Request-level controller for the SRAM macro; it sits directly upstream of the write driver.
- Accepts one read or write request at a time over a valid/ready interface.
- Splits the address into a row and a column, then drives precharge, the one-hot wordline and one-hot col_select, plus write_en/data_out to the write driver or sense_en to the sense amps.
- Returns a single-cycle response pulse carrying the read data.

Parameters:
- WORD_SIZE, 4, bits per word; width of data_out, sense_data, req_wdata and rsp_rdata.
- NUM_WORDS, 16, words per row; width of the one-hot col_select. Must be a power of 2.
- NUM_ROWS, 16, number of wordlines. Must be a power of 2.
- PRE_CYCLES, 1, precharge cycles per access. Must be ≥1.
- ACC_CYCLES, 2, wordline-active cycles per access. Must be ≥1.
- COL_W (localparam), $clog2(NUM_WORDS). ROW_W (localparam), $clog2(NUM_ROWS). ADDR_W (localparam), ROW_W+COL_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  {row, col}: row = req_addr[ADDR_W-1:COL_W], col = req_addr[COL_W-1:0].
- req_wdata  in  WORD_SIZE  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  WORD_SIZE  read data; valid when rsp_valid is high and the request was a read.
- precharge_en  out  1  bitline precharge.
- wordline  out  NUM_ROWS  one-hot row select.
- col_select  out  NUM_WORDS  one-hot column select, to the write driver and the sense mux.
- write_en  out  1  write driver enable.
- data_out  out  WORD_SIZE  data to the write driver's data_in.
- sense_en  out  1  sense amp enable.
- sense_data  in  WORD_SIZE  sensed word, already column-muxed by the sense path.

Behaviour:
- Reset (rst_n=0 at an edge):
  - FSM goes to IDLE; cycle counter, latched address/we/wdata and rsp_rdata clear to 0.
  - Reset values: req_ready=1, rsp_valid=0, precharge_en=0, wordline=0, col_select=0, write_en=0, sense_en=0, data_out=0.
  - Reset mid-access aborts the access: no response is issued, and wordline/write_en drop at the reset edge.
- Array-control outputs are decoded from registered state only. There is no combinational path from req_* to the array pins.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch addr/we/wdata, load counter=PRE_CYCLES-1, go to PRECHARGE.
  - PRECHARGE: precharge_en=1, all other array controls 0. Counter decrements each cycle; at 0, load ACC_CYCLES-1 and go to ACTIVE.
  - ACTIVE:
    - wordline = one-hot(row) and col_select = one-hot(col).
    - Write: write_en=1, data_out = latched wdata.
    - Read: sense_en=1, data_out=0.
    - In the last ACTIVE cycle (counter=0), a read captures sense_data into rsp_rdata at the edge; then go to DONE.
  - DONE: rsp_valid=1 for exactly one cycle, all array controls 0, then IDLE.
- Response and acceptance:
  - A write leaves rsp_rdata unchanged.
  - req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored; the requester holds it.
- Latency: for an accept at edge T, rsp_valid is high during cycle T+PRE_CYCLES+ACC_CYCLES+1 (default: 4 cycles after accept).
- Back-to-back requests: the next request is accepted at the earliest in the IDLE cycle following DONE. Per-request throughput is PRE_CYCLES+ACC_CYCLES+2 cycles.
- Invariants:
  - wordline and col_select are each either all-zero or exactly one-hot.
  - write_en and sense_en are never both high.
  - precharge_en is never high together with a wordline bit.
- Address boundaries: 0 selects wordline[0]/col_select[0]; all-ones selects wordline[NUM_ROWS-1]/col_select[NUM_WORDS-1]. No out-of-range case exists (power-of-2 sizes).

Optional Feature:
- Macro: SRAM_ACCESS_CTRL_RD_FWD_EN.
- With the macro defined:
  - A last-write register (addr, data, valid bit) updates on every write that reaches DONE.
  - A read accepted in IDLE whose address matches a valid last-write entry goes IDLE→DONE directly. rsp_rdata gets the forwarded data, and there is no PRECHARGE/ACTIVE (latency 1).
  - Reset clears the valid bit.
- Without the macro: every read goes through the array. The register and the extra state path are absent.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 → req_ready=1, all array outputs 0, rsp_valid=0, no accept.
- Write addr=8'h3A, wdata=4'hB, defaults → 1 cycle precharge_en; then 2 cycles of wordline=16'h0008, col_select=16'h0400, write_en=1, data_out=4'hB; rsp_valid at accept+4.
- Read addr=8'hFF with sense_data=4'h6 → wordline[15], col_select[15], sense_en 2 cycles; rsp_rdata=4'h6 with rsp_valid at accept+4.
- Back-to-back: req_valid held high with write 0x00 then read 0x00 → second accept in the IDLE cycle after DONE; req_ready=0 throughout the first access.
- Abort: rst_n=0 during the second ACTIVE cycle of a write → write_en and wordline 0 after that edge, no rsp_valid, req_ready=1 after release.
- With SRAM_ACCESS_CTRL_RD_FWD_EN: write 0x12=4'h5, then read 0x12 → rsp_valid the cycle after accept, rsp_rdata=4'h5, precharge_en never asserted; read 0x13 → full array access.
